// File: rtl/dbg_bus_master.sv
// Debug-port bus master: parses a byte-serial command stream, drives halt and the
// debug master bus port, and returns response bytes to the UART transmitter.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | waiting for an opcode byte
// S_ADDR     | collecting 4 address bytes, little-endian
// S_DATA     | collecting 4 write-data bytes, little-endian
// S_BUS_RD   | single read request cycle (dbg_mode=01)
// S_BUS_WAIT | remaining read latency, address held, mode idle
// S_BUS_WR   | single write request cycle (dbg_mode=10)
// S_RESP     | streaming response bytes, LSB first
module dbg_bus_master #(
    parameter int READ_LATENCY   = 1,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter bit HALT_ON_RESET  = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        ds_cpu_halt,
    output logic [31:0] dbg_address,
    output logic [31:0] dbg_write_data,
    output logic [1:0]  dbg_reqw,
    output logic [1:0]  dbg_mode,
    output logic        dbg_reqs,
    input  logic [31:0] dbg_read_data
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int LW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [7:0] ACK = 8'hA5;
    localparam logic [7:0] ERR = 8'hEE;

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_DATA, S_BUS_RD, S_BUS_WAIT, S_BUS_WR, S_RESP
    } state_t;

    state_t        state_q, state_d;
    logic          halt_q, halt_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          is_wr_q, is_wr_d;
    logic [1:0]    byte_cnt_q, byte_cnt_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic [LW-1:0] lat_cnt_q, lat_cnt_d;
    logic [31:0]   resp_q, resp_d;
    logic [1:0]    resp_left_q, resp_left_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            halt_q      <= HALT_ON_RESET;
            addr_q      <= '0;
            wdata_q     <= '0;
            is_wr_q     <= 1'b0;
            byte_cnt_q  <= '0;
            to_cnt_q    <= '0;
            lat_cnt_q   <= '0;
            resp_q      <= '0;
            resp_left_q <= '0;
        end else begin
            state_q     <= state_d;
            halt_q      <= halt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            is_wr_q     <= is_wr_d;
            byte_cnt_q  <= byte_cnt_d;
            to_cnt_q    <= to_cnt_d;
            lat_cnt_q   <= lat_cnt_d;
            resp_q      <= resp_d;
            resp_left_q <= resp_left_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        halt_d      = halt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        is_wr_d     = is_wr_q;
        byte_cnt_d  = byte_cnt_q;
        to_cnt_d    = to_cnt_q;
        lat_cnt_d   = lat_cnt_q;
        resp_d      = resp_q;
        resp_left_d = resp_left_q;

        case (state_q)
            S_IDLE: begin
                if (rx_valid) begin
                    resp_left_d = 2'd0;
                    case (rx_data)
                        8'h01: begin halt_d = 1'b1; resp_d = {24'd0, ACK}; state_d = S_RESP; end
                        8'h02: begin halt_d = 1'b0; resp_d = {24'd0, ACK}; state_d = S_RESP; end
                        8'h03, 8'h04: begin
                            is_wr_d    = (rx_data == 8'h04);
                            byte_cnt_d = 2'd0;
                            to_cnt_d   = '0;
                            state_d    = S_ADDR;
                        end
                        default: begin resp_d = {24'd0, ERR}; state_d = S_RESP; end
                    endcase
                end
            end
            S_ADDR, S_DATA: begin
                if (rx_valid) begin
                    to_cnt_d   = '0;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (state_q == S_ADDR) addr_d  = {rx_data, addr_q[31:8]};
                    else                   wdata_d = {rx_data, wdata_q[31:8]};
                    if (byte_cnt_q == 2'd3) begin
                        resp_left_d = 2'd0;
                        if (state_q == S_ADDR && is_wr_q) begin
                            state_d = S_DATA;
                        end else if (halt_q) begin
                            state_d = is_wr_q ? S_BUS_WR : S_BUS_RD;
                        end else begin
                            resp_d  = {24'd0, ERR};
                            state_d = S_RESP;
                        end
                    end
                end else if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    // Inter-byte gap too long: silently drop the partial command.
                    to_cnt_d = '0;
                    state_d  = S_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            S_BUS_RD: begin
                if (READ_LATENCY == 1) begin
                    resp_d      = dbg_read_data;
                    resp_left_d = 2'd3;
                    state_d     = S_RESP;
                end else begin
                    lat_cnt_d = LW'(READ_LATENCY - 2);
                    state_d   = S_BUS_WAIT;
                end
            end
            S_BUS_WAIT: begin
                if (lat_cnt_q == '0) begin
                    resp_d      = dbg_read_data;
                    resp_left_d = 2'd3;
                    state_d     = S_RESP;
                end else begin
                    lat_cnt_d = lat_cnt_q - 1'b1;
                end
            end
            S_BUS_WR: begin
                resp_d      = {24'd0, ACK};
                resp_left_d = 2'd0;
                state_d     = S_RESP;
            end
            S_RESP: begin
                if (tx_ready) begin
                    if (resp_left_q == 2'd0) begin
                        state_d = S_IDLE;
                    end else begin
                        resp_d      = {8'd0, resp_q[31:8]};
                        resp_left_d = resp_left_q - 2'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign tx_valid       = (state_q == S_RESP);
    assign tx_data        = resp_q[7:0];
    assign ds_cpu_halt    = halt_q;
    assign dbg_address    = addr_q;
    assign dbg_write_data = wdata_q;
    assign dbg_reqw       = 2'b10;
    assign dbg_reqs       = 1'b0;
    assign dbg_mode       = (state_q == S_BUS_RD && halt_q) ? 2'b01 :
                            (state_q == S_BUS_WR && halt_q) ? 2'b10 : 2'b00;

endmodule

// File: tb/tb_dbg_bus_master.sv
// Scoreboard bench for dbg_bus_master: random command stream against a command-level
// model, with separate monitors for the transmit stream and the bus port.
module tb_dbg_bus_master;

    localparam int RL = 3;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        ds_cpu_halt;
    logic [31:0] dbg_address;
    logic [31:0] dbg_write_data;
    logic [1:0]  dbg_reqw;
    logic [1:0]  dbg_mode;
    logic        dbg_reqs;
    logic [31:0] dbg_read_data = 32'h0;

    dbg_bus_master #(.READ_LATENCY(RL), .TIMEOUT_CYCLES(TO), .HALT_ON_RESET(1'b0)) dut (
        .clk(clk), .reset(reset),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .ds_cpu_halt(ds_cpu_halt),
        .dbg_address(dbg_address), .dbg_write_data(dbg_write_data),
        .dbg_reqw(dbg_reqw), .dbg_mode(dbg_mode), .dbg_reqs(dbg_reqs),
        .dbg_read_data(dbg_read_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  mode;
        logic [31:0] addr;
        logic [31:0] data;
    } bus_t;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [7:0]  exp_tx[$];
    bus_t        exp_bus[$];
    logic [31:0] mem[logic [31:0]];
    bit          model_halt = 1'b0;
    bit          slow = 1'b0;
    int          slow_cnt = 0;
    int          rd_cnt = 0;
    logic [31:0] rd_val = 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    // Bus slave: read data is valid only in the cycle that lets the master capture it
    // exactly RL cycles after the request; any other cycle carries corrupted data.
    always @(posedge clk) begin
        #1;
        if (dbg_mode == 2'b01) begin
            rd_cnt = 1;
            rd_val = mem_rd(dbg_address);
        end else if (rd_cnt != 0) begin
            rd_cnt = (rd_cnt >= RL) ? 0 : rd_cnt + 1;
        end
        dbg_read_data = (rd_cnt == RL) ? rd_val : (~rd_val ^ 32'h1);
    end

    always @(posedge clk) begin
        #1;
        if (slow) begin
            slow_cnt = (slow_cnt == 5) ? 0 : slow_cnt + 1;
            tx_ready = (slow_cnt == 5);
        end else begin
            tx_ready = ($urandom_range(0, 2) != 0);
        end
    end

    logic [7:0] prev_data = 8'h00;
    bit         prev_stall = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("tx_hold_valid", 32'(tx_valid), 32'h1);
                check("tx_hold_data", 32'(tx_data), 32'(prev_data));
            end
            if (tx_valid && tx_ready) begin
                if (exp_tx.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL tx_unexpected: got %h expected no byte", tx_data);
                end else begin
                    check("tx_byte", 32'(tx_data), 32'(exp_tx.pop_front()));
                end
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
        end
    end

    always @(negedge clk) begin
        if (!reset && dbg_mode != 2'b00) begin
            check("bus_halted", 32'(ds_cpu_halt), 32'h1);
            check("bus_reqw", 32'(dbg_reqw), 32'h2);
            check("bus_reqs", 32'(dbg_reqs), 32'h0);
            if (exp_bus.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL bus_unexpected: got mode %b addr %h expected idle", dbg_mode, dbg_address);
            end else begin
                bus_t e;
                e = exp_bus.pop_front();
                check("bus_mode", 32'(dbg_mode), 32'(e.mode));
                check("bus_addr", dbg_address, e.addr);
                if (e.mode == 2'b10) check("bus_wdata", dbg_write_data, e.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_tx.size() != 0 || exp_bus.size() != 0) && n < 3000) begin
            tick();
            n++;
        end
        if (n >= 3000) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d tx / %0d bus pending expected 0", exp_tx.size(), exp_bus.size());
            exp_tx.delete();
            exp_bus.delete();
        end
        tick();
    endtask

    task automatic apply_model(input logic [7:0] op, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] v;
        case (op)
            8'h01: begin model_halt = 1'b1; exp_tx.push_back(8'hA5); end
            8'h02: begin model_halt = 1'b0; exp_tx.push_back(8'hA5); end
            8'h03: begin
                if (model_halt) begin
                    exp_bus.push_back('{2'b01, a, 32'h0});
                    v = mem_rd(a);
                    for (int k = 0; k < 4; k++) exp_tx.push_back(v[8*k +: 8]);
                end else begin
                    exp_tx.push_back(8'hEE);
                end
            end
            8'h04: begin
                if (model_halt) begin
                    exp_bus.push_back('{2'b10, a, d});
                    mem[a] = d;
                    exp_tx.push_back(8'hA5);
                end else begin
                    exp_tx.push_back(8'hEE);
                end
            end
            default: exp_tx.push_back(8'hEE);
        endcase
    endtask

    // abort_at >= 1 stops after that many bytes and idles past the timeout.
    task automatic run_cmd(input logic [7:0] op, input logic [31:0] a, input logic [31:0] d,
                           input int abort_at, input bit rnd, input bit do_wait);
        logic [7:0] b [9];
        int n;
        n = (op == 8'h03) ? 5 : (op == 8'h04) ? 9 : 1;
        b[0] = op;
        for (int k = 0; k < 4; k++) begin
            b[1+k] = a[8*k +: 8];
            b[5+k] = d[8*k +: 8];
        end
        for (int i = 0; i < n; i++) begin
            if (i > 0 && i == abort_at) begin
                repeat (TO + $urandom_range(0, 2)) tick();
                return;
            end
            if (i > 0 && rnd) begin
                if ($urandom_range(0, 9) == 0) repeat (TO - 1) tick();
                else repeat ($urandom_range(0, 2)) tick();
            end
            send_byte(b[i]);
        end
        apply_model(op, a, d);
        if (rnd && $urandom_range(0, 2) == 0) send_byte(model_halt ? 8'h02 : 8'h01);
        if (do_wait) wait_drain();
    endtask

    initial begin
        logic [7:0]  op;
        logic [31:0] a;
        int          ab;
        int          n;

        repeat (3) tick();
        check("rst_tx_valid", 32'(tx_valid), 32'h0);
        check("rst_halt", 32'(ds_cpu_halt), 32'h0);
        check("rst_mode", 32'(dbg_mode), 32'h0);
        check("rst_addr", dbg_address, 32'h0);
        check("rst_wdata", dbg_write_data, 32'h0);
        check("rst_tx_data", 32'(tx_data), 32'h0);
        check("rst_reqw", 32'(dbg_reqw), 32'h2);
        check("rst_reqs", 32'(dbg_reqs), 32'h0);
        reset = 1'b0;
        tick();

        run_cmd(8'h01, 32'h0, 32'h0, -1, 1'b0, 1'b1);
        check("halt_after_cmd", 32'(ds_cpu_halt), 32'h1);
        run_cmd(8'h04, 32'h00003000, 32'hDEADBEEF, -1, 1'b0, 1'b1);
        run_cmd(8'h03, 32'h00003000, 32'h0, -1, 1'b0, 1'b1);
        slow = 1'b1;
        run_cmd(8'h03, 32'h00003000, 32'h0, -1, 1'b0, 1'b1);
        slow = 1'b0;
        run_cmd(8'h01, 32'h0, 32'h0, -1, 1'b0, 1'b1);
        run_cmd(8'h02, 32'h0, 32'h0, -1, 1'b0, 1'b1);
        check("resume_after_cmd", 32'(ds_cpu_halt), 32'h0);
        run_cmd(8'h02, 32'h0, 32'h0, -1, 1'b0, 1'b1);
        run_cmd(8'h03, 32'h000040F0, 32'h0, -1, 1'b0, 1'b1);
        run_cmd(8'h7F, 32'h0, 32'h0, -1, 1'b0, 1'b1);
        run_cmd(8'h03, 32'h0, 32'h0, 2, 1'b0, 1'b1);
        run_cmd(8'h02, 32'h0, 32'h0, -1, 1'b0, 1'b1);

        for (int t = 0; t < 200; t++) begin
            case ($urandom_range(0, 9))
                0, 1:    op = 8'h01;
                2:       op = 8'h02;
                3, 4, 5: op = 8'h03;
                6, 7:    op = 8'h04;
                default: op = 8'($urandom_range(0, 255));
            endcase
            a = ($urandom_range(0, 1) == 0) ? (32'h3000 + 32'($urandom_range(0, 7)) * 4) : $urandom;
            n = (op == 8'h03) ? 5 : (op == 8'h04) ? 9 : 1;
            ab = (n > 1 && $urandom_range(0, 11) == 0) ? $urandom_range(1, n - 1) : -1;
            run_cmd(op, a, $urandom, ab, 1'b1, 1'b1);
            check("halt_track", 32'(ds_cpu_halt), 32'(model_halt));
        end

        run_cmd(8'h01, 32'h0, 32'h0, -1, 1'b0, 1'b1);
        slow = 1'b1;
        run_cmd(8'h03, 32'h00003004, 32'h0, -1, 1'b0, 1'b0);
        n = 0;
        while (exp_tx.size() > 3 && n < 500) begin
            tick();
            n++;
        end
        check("mid_resp_reached", 32'(n < 500), 32'h1);
        check("mid_resp_valid", 32'(tx_valid), 32'h1);
        reset = 1'b1;
        exp_tx.delete();
        exp_bus.delete();
        model_halt = 1'b0;
        #1;
        check("rst_mid_tx_valid", 32'(tx_valid), 32'h0);
        check("rst_mid_halt", 32'(ds_cpu_halt), 32'h0);
        check("rst_mid_mode", 32'(dbg_mode), 32'h0);
        tick();
        check("rst_mid_tx_valid_next", 32'(tx_valid), 32'h0);
        reset = 1'b0;
        slow = 1'b0;
        tick();
        run_cmd(8'h02, 32'h0, 32'h0, -1, 1'b0, 1'b1);
        check("end_tx_queue", 32'(exp_tx.size()), 32'h0);
        check("end_bus_queue", 32'(exp_bus.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
